// File: rtl/seg_scan_mux_pkg.sv
// Shared types and constants for the 3-digit scan multiplexer.
// Holds the scan phase, the slot index and the displayed-word struct.
package seg_pkg;
  localparam int         N_DIG  = 3;
  localparam logic [2:0] AN_OFF = 3'b111;

  typedef enum logic {PH_BLANK, PH_ON} phase_e;
  typedef logic [1:0] slot_t;

  typedef struct packed {
    logic [11:0] value;
    logic [2:0]  dp;
  } disp_t;

  function automatic logic [3:0] nib(input logic [11:0] v, input slot_t s);
    case (s)
      2'd1:    nib = v[7:4];
      2'd2:    nib = v[11:8];
      default: nib = v[3:0];
    endcase
  endfunction
endpackage

// File: rtl/seg_scan_mux_if.sv
// Load/display bus between the value producer and the scan multiplexer.
interface seg_scan_mux_if;
  logic        load;
  logic [11:0] value;
  logic [2:0]  dp_in;
  logic        blank_lz;
  logic [3:0]  digit;
  logic [2:0]  an;
  logic        dp;
  logic        frame_sof;

  modport master (output load, value, dp_in, blank_lz,
                  input  digit, an, dp, frame_sof);
  modport slave  (input  load, value, dp_in, blank_lz,
                  output digit, an, dp, frame_sof);
endinterface

// File: rtl/seg_scan_mux_scan_timer.sv
// Slot counter and slot rotation; one slot is REFRESH_DIV cycles,
// the first GUARD of which are the blank phase.
module scan_timer
  import seg_pkg::*;
#(
  parameter int REFRESH_DIV = 50000,
  parameter int GUARD       = 64
) (
  input  logic                           clk,
  input  logic                           clr,
  output logic [$clog2(REFRESH_DIV)-1:0] cnt_o,
  output slot_t                          slot_o,
  output phase_e                         phase_o,
  output logic                           slot_start_o,
  output logic                           sof_o
);
  localparam int CW = $clog2(REFRESH_DIV);

  logic [CW-1:0] cnt_q, cnt_d;
  slot_t         slot_q, slot_d;
  logic          wrap;

  always_comb begin
    wrap   = (cnt_q == CW'(REFRESH_DIV - 1));
    cnt_d  = wrap ? '0 : cnt_q + CW'(1);
    slot_d = slot_q;
    if (wrap) slot_d = (slot_q == 2'd2) ? 2'd0 : slot_q + 2'd1;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      cnt_q  <= '0;
      slot_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      slot_q <= slot_d;
    end
  end

  assign cnt_o        = cnt_q;
  assign slot_o       = slot_q;
  assign phase_o      = (int'(cnt_q) < GUARD) ? PH_BLANK : PH_ON;
  assign slot_start_o = (cnt_q == '0);
  assign sof_o        = (cnt_q == '0) && (slot_q == 2'd0);
endmodule

// File: rtl/seg_scan_mux.sv
// Time-multiplexes a 12-bit value over 3 common-anode digits with guard
// blanking, frame-atomic value updates and optional leading-zero blanking.
module seg_scan_mux
  import seg_pkg::*;
#(
  parameter int REFRESH_DIV = 50000,
  parameter int GUARD       = 64
) (
  input logic           clk,
  input logic           clr,
  seg_scan_mux_if.slave bus
);
  localparam int CW = $clog2(REFRESH_DIV);

  logic [CW-1:0] cnt;
  slot_t         slot;
  phase_e        phase;
  logic          slot_start, sof;

  scan_timer #(.REFRESH_DIV(REFRESH_DIV), .GUARD(GUARD)) u_timer (
    .clk          (clk),
    .clr          (clr),
    .cnt_o        (cnt),
    .slot_o       (slot),
    .phase_o      (phase),
    .slot_start_o (slot_start),
    .sof_o        (sof)
  );

  disp_t      pend_q, pend_d, shad_q, shad_d, ld_word;
  logic       dirty_q, dirty_d;
  logic       blank_q, blank_d, blank_calc;
  logic [3:0] digit_q, digit_d;
  logic [2:0] an_q, an_d;
  logic       dp_q, dp_d, sof_q;

  // Output registers lag the timer by one cycle, so the timer's (slot 0, cnt 0)
  // cycle is the edge at which the shadow may take a new frame value.
  always_comb begin
    ld_word = '{value: bus.value, dp: bus.dp_in};
    pend_d  = pend_q;
    dirty_d = dirty_q;
    shad_d  = shad_q;
    if (bus.load) begin
      pend_d  = ld_word;
      dirty_d = 1'b1;
    end
    if (sof) begin
      if (bus.load)     shad_d = ld_word;
      else if (dirty_q) shad_d = pend_q;
      dirty_d = 1'b0;
    end
  end

  always_comb begin
    blank_calc = bus.blank_lz &&
                 ((slot == 2'd2 && shad_d.value[11:8] == 4'h0) ||
                  (slot == 2'd1 && shad_d.value[11:4] == 8'h00));
    blank_d = slot_start ? blank_calc : blank_q;
    digit_d = slot_start ? nib(shad_d.value, slot) : digit_q;
    dp_d    = slot_start ? (blank_calc | ~shad_d.dp[slot]) : dp_q;
    an_d    = (phase == PH_ON && !blank_d) ? ~(3'b001 << slot) : AN_OFF;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      pend_q  <= '0;
      shad_q  <= '0;
      dirty_q <= 1'b0;
      blank_q <= 1'b0;
      digit_q <= 4'h0;
      an_q    <= AN_OFF;
      dp_q    <= 1'b1;
      sof_q   <= 1'b0;
    end else begin
      pend_q  <= pend_d;
      shad_q  <= shad_d;
      dirty_q <= dirty_d;
      blank_q <= blank_d;
      digit_q <= digit_d;
      an_q    <= an_d;
      dp_q    <= dp_d;
      sof_q   <= sof;
    end
  end

  assign bus.digit     = digit_q;
  assign bus.an        = an_q;
  assign bus.dp        = dp_q;
  assign bus.frame_sof = sof_q;
endmodule

// File: tb/tb_seg_scan_mux.sv
// Self-checking bench for seg_scan_mux (REFRESH_DIV=8, GUARD=2) against a
// cycle-indexed model of what each digit slot should show.
module tb_seg_scan_mux;
  localparam int RD = 8;
  localparam int GD = 2;
  localparam int FR = 3 * RD;

  logic clk = 1'b0;
  logic clr = 1'b1;
  seg_scan_mux_if bus ();

  seg_scan_mux #(.REFRESH_DIV(RD), .GUARD(GD)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int nchk = 0;
  int nerr = 0;
  int t    = -1;
  bit blz  = 1'b0;

  int          ld_t[$];
  logic [11:0] ld_v[$];
  logic [2:0]  ld_d[$];

  // Expected {an, digit, dp, frame_sof} at output cycle tc: a frame shows the
  // last load sampled before the frame's first cycle.
  function automatic logic [8:0] exp_out(int tc);
    int          fs   = (tc / FR) * FR;
    int          slot = (tc / RD) % 3;
    int          cnt  = tc % RD;
    logic [11:0] v    = 12'h000;
    logic [2:0]  d    = 3'b000;
    logic [2:0]  an;
    logic [3:0]  dg;
    bit          blank;
    for (int i = 0; i < ld_t.size(); i++)
      if (ld_t[i] < fs) begin
        v = ld_v[i];
        d = ld_d[i];
      end
    blank = blz && ((slot == 2 && v[11:8] == 4'h0) || (slot == 1 && v[11:4] == 8'h00));
    an    = (cnt < GD || blank) ? 3'b111 : ~(3'b001 << slot);
    dg    = 4'((v >> (4 * slot)) & 12'hF);
    return {an, dg, (blank ? 1'b1 : ~d[slot]), (tc % FR == 0)};
  endfunction

  task automatic tick(input bit ld, input logic [11:0] v, input logic [2:0] d);
    bus.load     = ld;
    bus.value    = v;
    bus.dp_in    = d;
    bus.blank_lz = blz;
    if (ld) begin
      ld_t.push_back(t);
      ld_v.push_back(v);
      ld_d.push_back(d);
    end
    @(posedge clk);
    #1;
    bus.load = 1'b0;
    t++;
  endtask

  task automatic do_clr();
    bus.load = 1'b0;
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    ld_t.delete();
    ld_v.delete();
    ld_d.delete();
    t = -1;
  endtask

  task automatic test_reset();
    logic [8:0] got;
    bus.load = 1'b0; bus.value = '0; bus.dp_in = '0; bus.blank_lz = 1'b0;
    clr = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    got = {bus.an, bus.digit, bus.dp, bus.frame_sof};
    nchk++;
    if (got !== {3'b111, 4'h0, 1'b1, 1'b0}) begin
      nerr++;
      $display("FAIL reset_values got=%h exp=%h", got, {3'b111, 4'h0, 1'b1, 1'b0});
    end
  endtask

  task automatic test_no_load();
    logic [8:0] got, exp;
    blz = 1'b0;
    do_clr();
    repeat (2 * FR + 1) begin
      tick(1'b0, 12'h0, 3'b0);
      got = {bus.an, bus.digit, bus.dp, bus.frame_sof};
      exp = exp_out(t);
      nchk++;
      if (got !== exp) begin
        nerr++;
        $display("FAIL no_load t=%0d got=%h exp=%h", t, got, exp);
      end
    end
  endtask

  task automatic test_load_midframe();
    logic [8:0] got, exp;
    blz = 1'b0;
    do_clr();
    while (t < 2 * FR) begin
      tick(t == 5, 12'hA5C, 3'b010);
      got = {bus.an, bus.digit, bus.dp, bus.frame_sof};
      exp = exp_out(t);
      nchk++;
      if (got !== exp) begin
        nerr++;
        $display("FAIL load_midframe t=%0d got=%h exp=%h", t, got, exp);
      end
      if (t == FR + RD + 3) begin
        nchk++;
        if (bus.digit !== 4'h5 || bus.dp !== 1'b0 || bus.an !== 3'b101) begin
          nerr++;
          $display("FAIL load_midframe_slot1 digit=%h dp=%b an=%b exp 5/0/101",
                   bus.digit, bus.dp, bus.an);
        end
      end
    end
  endtask

  task automatic test_bypass();
    logic [8:0]  got, exp;
    logic [11:0] v = 12'($urandom);
    logic [2:0]  d = 3'($urandom);
    blz = 1'b0;
    do_clr();
    while (t < 2 * FR) begin
      tick(t == FR - 1, v, d);
      got = {bus.an, bus.digit, bus.dp, bus.frame_sof};
      exp = exp_out(t);
      nchk++;
      if (got !== exp) begin
        nerr++;
        $display("FAIL bypass t=%0d got=%h exp=%h", t, got, exp);
      end
      if (t == FR) begin
        nchk++;
        if (bus.digit !== v[3:0]) begin
          nerr++;
          $display("FAIL bypass_first_cycle digit=%h exp=%h", bus.digit, v[3:0]);
        end
      end
    end
  endtask

  task automatic test_blank_lz();
    logic [8:0] got, exp;
    blz = 1'b1;
    do_clr();
    while (t < 3 * FR) begin
      tick(t == 5, 12'h007, 3'b111);
      got = {bus.an, bus.digit, bus.dp, bus.frame_sof};
      exp = exp_out(t);
      nchk++;
      if (got !== exp) begin
        nerr++;
        $display("FAIL blank_lz t=%0d got=%h exp=%h", t, got, exp);
      end
    end
    blz = 1'b0;
  endtask

  task automatic test_clr_mid();
    logic [8:0] got, exp;
    blz = 1'b0;
    do_clr();
    while (t < 13) tick(t == 10, 12'hBEE, 3'b101);
    clr = 1'b1;
    @(posedge clk);
    #1;
    got = {bus.an, bus.digit, bus.dp, bus.frame_sof};
    nchk++;
    if (got !== {3'b111, 4'h0, 1'b1, 1'b0}) begin
      nerr++;
      $display("FAIL clr_mid_reset got=%h exp=%h", got, {3'b111, 4'h0, 1'b1, 1'b0});
    end
    clr = 1'b0;
    ld_t.delete(); ld_v.delete(); ld_d.delete();
    t = -1;
    repeat (2 * FR) begin
      tick(1'b0, 12'h0, 3'b0);
      got = {bus.an, bus.digit, bus.dp, bus.frame_sof};
      exp = exp_out(t);
      nchk++;
      if (got !== exp) begin
        nerr++;
        $display("FAIL clr_mid t=%0d got=%h exp=%h", t, got, exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [8:0] got, exp;
    blz = 1'b0;
    do_clr();
    while (t < 2 * FR) begin
      if (t == 3)       tick(1'b1, 12'h111, 3'b000);
      else if (t == 10) tick(1'b1, 12'h222, 3'b000);
      else              tick(1'b0, 12'h0, 3'b0);
      got = {bus.an, bus.digit, bus.dp, bus.frame_sof};
      exp = exp_out(t);
      nchk++;
      if (got !== exp) begin
        nerr++;
        $display("FAIL back_to_back t=%0d got=%h exp=%h", t, got, exp);
      end
      if (t >= FR && bus.an != 3'b111) begin
        nchk++;
        if (bus.digit !== 4'h2) begin
          nerr++;
          $display("FAIL back_to_back_digit t=%0d digit=%h exp=2", t, bus.digit);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [8:0] got, exp;
    bit         ld;
    for (int run = 0; run < 4; run++) begin
      blz = 1'($urandom);
      do_clr();
      while (t < 4 * FR) begin
        ld = ($urandom_range(0, 9) == 0) || (t % FR == FR - 1 && $urandom_range(0, 1) == 1);
        tick(ld, ($urandom_range(0, 2) == 0) ? 12'($urandom_range(0, 15)) : 12'($urandom),
             3'($urandom));
        got = {bus.an, bus.digit, bus.dp, bus.frame_sof};
        exp = exp_out(t);
        nchk++;
        if (got !== exp) begin
          nerr++;
          $display("FAIL random run=%0d t=%0d got=%h exp=%h", run, t, got, exp);
        end
      end
    end
    blz = 1'b0;
  endtask

  initial begin
    test_reset();
    test_no_load();
    test_load_midframe();
    test_bypass();
    test_blank_lz();
    test_clr_mid();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
